// File: rtl/busca_instrucao.sv
// Instruction-fetch sequencer: fetches the word at SaidaPC, offers it to decode,
// then writes PC+INC_PC or a branch target back to the PC register.
module busca_instrucao #(
  parameter int LARG_INSTR = 16,
  parameter int INC_PC     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            SaidaPC,
  output logic [7:0]            EntradaPC,
  output logic                  EscPC,
  output logic [7:0]            MemEnd,
  output logic                  MemReq,
  input  logic                  MemAck,
  input  logic [LARG_INSTR-1:0] MemDado,
  output logic                  InstrValida,
  input  logic                  Pronto,
  output logic [LARG_INSTR-1:0] Instrucao,
  output logic [7:0]            PCInstr,
  input  logic                  Desvio,
  input  logic [7:0]            AlvoDesvio,
  input  logic                  Parar
);

  typedef enum logic [1:0] {OCIOSO, BUSCA, ENTREGA, ATUALIZA} estado_t;

  localparam logic [7:0] INC = 8'(INC_PC);

  estado_t               estado_q, estado_d;
  logic                  pend_q, pend_d;
  logic [7:0]            alvo_q, alvo_d;
  logic [LARG_INSTR-1:0] instr_q, instr_d;
  logic [7:0]            pcinstr_q, pcinstr_d;

  // A branch arriving in ATUALIZA itself beats any target recorded earlier.
  function automatic logic [7:0] prox_pc(input logic       desvio,
                                         input logic [7:0] alvo,
                                         input logic       pend,
                                         input logic [7:0] alvo_pend,
                                         input logic [7:0] pc);
    if (desvio)    return alvo;
    else if (pend) return alvo_pend;
    else           return pc + INC;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      pend_q    <= 1'b0;
      alvo_q    <= '0;
      instr_q   <= '0;
      pcinstr_q <= '0;
    end else begin
      estado_q  <= estado_d;
      pend_q    <= pend_d;
      alvo_q    <= alvo_d;
      instr_q   <= instr_d;
      pcinstr_q <= pcinstr_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    pend_d      = pend_q;
    alvo_d      = alvo_q;
    instr_d     = instr_q;
    pcinstr_d   = pcinstr_q;
    MemReq      = 1'b0;
    MemEnd      = '0;
    InstrValida = 1'b0;
    EscPC       = 1'b0;
    EntradaPC   = '0;
    case (estado_q)
      OCIOSO: begin
        if (!Parar) estado_d = BUSCA;
      end
      BUSCA: begin
        MemReq = 1'b1;
        MemEnd = SaidaPC;
        if (Desvio) begin
          pend_d = 1'b1;
          alvo_d = AlvoDesvio;
        end
        if (MemAck) begin
          instr_d   = MemDado;
          pcinstr_d = SaidaPC;
          // A word fetched under a pending or concurrent branch is stale.
          estado_d  = (!pend_q && !Desvio) ? ENTREGA : ATUALIZA;
        end
      end
      ENTREGA: begin
        InstrValida = 1'b1;
        if (Desvio) begin
          pend_d = 1'b1;
          alvo_d = AlvoDesvio;
        end
        if (Pronto || Desvio) estado_d = ATUALIZA;
      end
      ATUALIZA: begin
        EscPC     = 1'b1;
        EntradaPC = prox_pc(Desvio, AlvoDesvio, pend_q, alvo_q, SaidaPC);
        pend_d    = 1'b0;
        estado_d  = Parar ? OCIOSO : BUSCA;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign Instrucao = instr_q;
  assign PCInstr   = pcinstr_q;

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch sequencer for the 8-bit multicycle core. It reads the current program counter, fetches the instruction word from instruction memory over a req/ack handshake, and hands the word to decode over a valid/ready handshake. It then drives the PC register's write port (`EntradaPC`/`EscPC`) with either PC+1 or a pending branch target. It sits between the PC register and the decode/execute stages and is the only writer of the PC.

## Interface

Parameters:
- `LARG_INSTR`, default 16: instruction word width.
- `INC_PC`, default 1: sequential PC increment.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset (one clock; async active-low reset).
- `SaidaPC`, in, 8: current PC value from the PC register.
- `EntradaPC`, out, 8: next PC value to the PC register.
- `EscPC`, out, 1: PC write enable, one-cycle pulse.
- `MemEnd`, out, 8: instruction memory address.
- `MemReq`, out, 1: memory request.
- `MemAck`, in, 1: memory acknowledge; `MemDado` is valid in the same cycle.
- `MemDado`, in, `LARG_INSTR`: instruction word from memory.
- `InstrValida`, out, 1: instruction available to decode.
- `Pronto`, in, 1: decode accepts the instruction.
- `Instrucao`, out, `LARG_INSTR`: latched instruction word.
- `PCInstr`, out, 8: PC of the latched instruction.
- `Desvio`, in, 1: branch taken, one-cycle pulse from execute.
- `AlvoDesvio`, in, 8: branch target; valid when `Desvio`=1.
- `Parar`, in, 1: halt request; stops new fetches.

## Operation

- FSM states: OCIOSO (reset state), BUSCA, ENTREGA, ATUALIZA.
- **OCIOSO:** all handshake outputs low. Next state is BUSCA if `Parar`=0, else stay. A stray `MemAck` is ignored.
- **BUSCA:**
  - `MemReq`=1 and `MemEnd`=`SaidaPC`. Both are held stable until `MemAck`.
  - On `MemAck`, register `MemDado` into `Instrucao` and `SaidaPC` into `PCInstr`.
  - If no branch is pending and `Desvio`=0, go to ENTREGA.
  - Otherwise discard the word (registers may update, `InstrValida` stays 0) and go to ATUALIZA.
- **ENTREGA:**
  - `InstrValida`=1; `Instrucao` and `PCInstr` are held.
  - `Pronto`=1 completes the transfer; go to ATUALIZA.
  - `Desvio`=1 without `Pronto` drops the instruction; go to ATUALIZA.
  - `Desvio` and `Pronto` in the same cycle: the transfer counts as done and the branch is recorded.
- **ATUALIZA:**
  - `EscPC`=1.
  - `EntradaPC` selection, highest priority first:
    - `AlvoDesvio` if `Desvio`=1 this cycle;
    - else the pending target if a branch is pending;
    - else (`SaidaPC` + `INC_PC`) mod 256, where 0xFF wraps to 0x00.
  - Clears the pending-branch flag.
  - Next state is OCIOSO if `Parar`=1, else BUSCA.
- **Pending branch:**
  - Any `Desvio` pulse in BUSCA or ENTREGA sets the pending flag and captures `AlvoDesvio`.
  - A later pulse overwrites the target (latest wins).
  - `Desvio` in OCIOSO is ignored.
- **`Parar`** never aborts an outstanding memory request or an offered instruction; it only takes effect at the OCIOSO/ATUALIZA exit decisions.
- **Output decode:** `MemReq`, `InstrValida` and `EscPC` are pure state decodes and are mutually exclusive. `EntradaPC` is 0 outside ATUALIZA.

## Timing

- **Reset** (asserted, asynchronous): state=OCIOSO, pending flag=0, pending target=0. `Instrucao`=0, `PCInstr`=0, `MemReq`=0, `InstrValida`=0, `EscPC`=0, `EntradaPC`=0, `MemEnd`=0.
- **Reset mid-operation:** an outstanding request is abandoned and any later `MemAck` is ignored.
- **Fetch after reset release:** the first `MemReq` is asserted in the cycle after reset deasserts with `Parar`=0.
- **Memory latency:** `MemAck` may arrive in the first BUSCA cycle (zero-wait memory).
- **Throughput:** the minimum cost per instruction is 3 cycles (BUSCA, ENTREGA, ATUALIZA). Each extra memory wait or decode stall cycle adds 1.
- **PC update:** the PC register loads `EntradaPC` at the edge ending ATUALIZA. The next BUSCA therefore presents the updated `SaidaPC` as `MemEnd`.

## Test plan

- **Sequential fetch:** reset, `SaidaPC`=0x00, zero-wait memory returning 0xA000+addr, `Pronto`=1. Expect:
  - `InstrValida` pulses every 3 cycles;
  - `Instrucao` 0xA000, 0xA001, 0xA002;
  - `EscPC` pulses with `EntradaPC` 0x01, 0x02, 0x03.
- **Wrap and waits:** PC=0xFF with `MemAck` delayed 4 cycles. Expect:
  - `MemReq` and `MemEnd`=0xFF held for 4 cycles;
  - `EntradaPC`=0x00 in ATUALIZA.
- **Decode stall:** `Pronto`=0 for 5 cycles. Expect `InstrValida`, `Instrucao` and `PCInstr` stable throughout, and no `EscPC` until the cycle after `Pronto`=1.
- **Branch during BUSCA:** `Desvio`=1, `AlvoDesvio`=0x40 while waiting for ack. Expect:
  - the word is discarded and `InstrValida` never rises;
  - `EntradaPC`=0x40;
  - the next `MemEnd`=0x40.
- **Branch/Pronto collision in ENTREGA:** `Desvio`=1 (target 0x10) in the same cycle as `Pronto`=1. Expect the transfer to complete, then `EntradaPC`=0x10. A second `Desvio` (target 0x20) in ATUALIZA overrides it, giving `EntradaPC`=0x20.
- **Halt and reset:** `Parar`=1 mid-request. Expect the request to complete, `InstrValida` to be offered, `EscPC` to pulse, then OCIOSO with no further `MemReq`. Asserting reset during BUSCA forces `MemReq`=0 immediately, and a following `MemAck` produces no `InstrValida`.
